// File: rtl/fixed_point_pkg.sv
// Shared Q-format constants and divider state encoding for the gradient-descent datapath.
// Pure declarations: no latency and no flow control live here.
package fixed_point_pkg;

  localparam int FRACT_BITS = 8;
  localparam int IN_W       = 16;
  localparam int OUT_W      = 32;
  localparam int QUO_W      = IN_W + FRACT_BITS;

  localparam logic [IN_W-1:0]  Q8_8_MAX  = 16'h7FFF;
  localparam logic [IN_W-1:0]  Q8_8_MIN  = 16'h8000;
  localparam logic [OUT_W-1:0] Q24_8_MAX = 32'h7FFF_FFFF;
  localparam logic [OUT_W-1:0] Q24_8_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // 0x8000 maps to 32768, which still fits the unsigned 16-bit result.
  function automatic logic [IN_W-1:0] abs_q88(input logic [IN_W-1:0] x);
    return x[IN_W-1] ? (~x + 16'd1) : x;
  endfunction

endpackage

// File: rtl/fixed_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
// Purely combinational, zero latency; no flow control.
module fixed_udiv_step (
  input  logic [16:0] rem,
  input  logic        n_bit,
  input  logic [15:0] den,
  output logic [16:0] rem_next,
  output logic        q_bit
);

  logic [16:0] shifted;

  // rem < den <= 2^15 always holds, so dropping rem[16] loses nothing.
  assign shifted = {rem[15:0], n_bit};

  always_comb begin
    q_bit    = 1'b0;
    rem_next = shifted;
    if (shifted >= {1'b0, den}) begin
      q_bit    = 1'b1;
      rem_next = shifted - {1'b0, den};
    end
  end

endmodule

// File: rtl/fixed_q88_seq_divider.sv
// Signed Q8.8 / Q8.8 -> Q24.8 restoring divider, one quotient bit per cycle; saturates on b=0.
// Latency 25 edges after accept (1 for b=0); result held in DONE until out_ready, in_ready only in IDLE.
module fixed_q88_seq_divider
  import fixed_point_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a_in,
  input  logic [IN_W-1:0]  b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] q_out,
  output logic             overflow,
  output logic             underflow_q,
  output logic             div_by_zero,
  output logic             busy
);

  div_state_t       state, state_nxt;
  logic [4:0]       cnt;
  logic [QUO_W-1:0] n_reg;
  logic [QUO_W-1:0] quo;
  logic [IN_W-1:0]  den;
  logic [16:0]      rem;
  logic             sign_r;

  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic [16:0]      rem_nxt;
  logic             q_bit;
  logic [OUT_W-1:0] mag;

  assign in_ready  = (state == DIV_IDLE);
  assign busy      = (state != DIV_IDLE);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (b_in == '0);
  assign last_iter = (cnt == 5'd23);
  assign mag       = {{(OUT_W-QUO_W){1'b0}}, quo};

  fixed_udiv_step u_step (
    .rem      (rem),
    .n_bit    (n_reg[QUO_W-1]),
    .den      (den),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = b_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last_iter) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DIV_DONE;
      DIV_DONE: if (out_ready) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      n_reg       <= '0;
      quo         <= '0;
      den         <= '0;
      rem         <= '0;
      sign_r      <= 1'b0;
      q_out       <= '0;
      overflow    <= 1'b0;
      underflow_q <= 1'b0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            sign_r <= a_in[IN_W-1] ^ b_in[IN_W-1];
            n_reg  <= {abs_q88(a_in), {FRACT_BITS{1'b0}}};
            den    <= abs_q88(b_in);
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            if (b_zero) begin
              // 0/0 reports only div_by_zero with a zero quotient.
              overflow    <= !a_in[IN_W-1] && (a_in != '0);
              underflow_q <= a_in[IN_W-1];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              if (a_in[IN_W-1])    q_out <= Q24_8_MIN;
              else if (a_in != '0) q_out <= Q24_8_MAX;
              else                 q_out <= '0;
            end
          end
        end
        DIV_CALC: begin
          rem   <= rem_nxt;
          n_reg <= {n_reg[QUO_W-2:0], 1'b0};
          quo   <= {quo[QUO_W-2:0], q_bit};
          cnt   <= last_iter ? 5'd0 : cnt + 5'd1;
        end
        DIV_FIX: begin
          q_out       <= sign_r ? (~mag + 32'd1) : mag;
          overflow    <= 1'b0;
          underflow_q <= 1'b0;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
        end
        DIV_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
